// File: rtl/text_pkg.sv
// Shared constants, state encoding and character mapping for the OLED text scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 16;
  localparam int CELLS = ROWS * COLS;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_FIRST = 8'h20;
  localparam logic [7:0] CHAR_LAST  = 8'h7E;

  localparam int FONT_BYTES_PER_CHAR = 16;

  // px_addr = {page, column}; page = {row, half}; column = {cidx, bcol}
  localparam int PAGE_W      = 3;
  localparam int COLUMN_W    = 7;
  localparam int PX_ADDR_W   = PAGE_W + COLUMN_W;
  localparam int ROW_W       = 2;
  localparam int CIDX_W      = 4;
  localparam int BCOL_W      = 3;
  localparam int CELL_W      = ROW_W + CIDX_W;
  localparam int FONT_ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Non-printable codes have no glyph in the ROM; draw them as blanks.
  function automatic logic [7:0] mapPrintable(input logic [7:0] c);
    if (c < CHAR_FIRST || c > CHAR_LAST) return CHAR_SPACE;
    return c;
  endfunction

endpackage

// File: rtl/text_char_buffer.sv
// 64-cell character store: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read data follows rdAddr in the same cycle.
// Backpressure: none; the owner arbitrates the single access slot.
// Ports: clk, rst_n (async, active low; all cells reset to space),
//        wrEn/wrAddr/wrChar (write), rdAddr/rdChar (read).
module text_char_buffer
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [CELL_W-1:0] wrAddr,
  input  logic [7:0]        wrChar,
  input  logic [CELL_W-1:0] rdAddr,
  output logic [7:0]        rdChar
);

  logic [7:0] mem [CELLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= CHAR_SPACE;
    end else if (wrEn) begin
      mem[wrAddr] <= wrChar;
    end
  end

  assign rdChar = mem[rdAddr];

endmodule

// File: rtl/text_scheduler.sv
// Serves OLED pixel-byte requests: buffer lookup, font-ROM fetch, one-cycle px_valid pulse.
// Latency: request seen in IDLE -> px_valid after FONT_LATENCY+3 edges (fifth cycle at default).
// Backpressure: px_req ignored while busy; host writes stalled (wr_ready=0) in CHAR or when a request starts.
// Ports: clk, rst_n (async active low); px_req/px_addr -> px_valid/px_data (driver side);
//        wr_valid/wr_ready/wr_addr/wr_char (host writer); font_addr -> font_data (external ROM); busy.
// Optional: define TEXT_SCHEDULER_CURSOR_EN for a blinking inverted cursor after the last written cell.
module text_scheduler
  import text_pkg::*;
#(
  parameter int FONT_LATENCY = 1
`ifdef TEXT_SCHEDULER_CURSOR_EN
  , parameter int BLINK_DIV = 24
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   px_req,
  input  logic [PX_ADDR_W-1:0]   px_addr,
  output logic                   px_valid,
  output logic [7:0]             px_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CELL_W-1:0]      wr_addr,
  input  logic [7:0]             wr_char,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  output logic                   busy
);

  localparam logic [1:0] WAIT_LOAD = 2'(FONT_LATENCY);

  state_t                 state, stateNext;
  logic [PX_ADDR_W-1:0]   reqAddr;
  logic [1:0]             waitCnt;
  logic                   wrAccept;
  logic [CELL_W-1:0]      reqCell;
  logic                   reqHalf;
  logic [BCOL_W-1:0]      reqBcol;
  logic [7:0]             cellChar;
  logic [7:0]             charOff;
  logic [FONT_ADDR_W-1:0] fontAddrNext;
  logic [7:0]             captureByte;

  // Decode of the latched request: row = page[2:1], half = page[0], cidx = column[6:3], bcol = column[2:0].
  assign reqCell = {reqAddr[PX_ADDR_W-1 -: ROW_W], reqAddr[COLUMN_W-1 -: CIDX_W]};
  assign reqHalf = reqAddr[COLUMN_W];
  assign reqBcol = reqAddr[BCOL_W-1:0];

  assign wrAccept = wr_valid && wr_ready;

  text_char_buffer uBuffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (wrAccept),
    .wrAddr (wr_addr),
    .wrChar (wr_char),
    .rdAddr (reqCell),
    .rdChar (cellChar)
  );

  assign charOff      = mapPrintable(cellChar) - CHAR_FIRST;
  assign fontAddrNext = FONT_ADDR_W'(charOff) * FONT_ADDR_W'(FONT_BYTES_PER_CHAR)
                      + FONT_ADDR_W'({reqHalf, reqBcol});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (px_req) stateNext = CHAR;
      CHAR:    stateNext = WAIT;
      WAIT:    if (waitCnt == 2'd0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs. The buffer port is owned by the read in CHAR, and also in the IDLE
  // cycle where a request is taken so the write cannot race the lookup.
  always_comb begin
    px_valid = (state == RESP);
    busy     = (state != IDLE);
    wr_ready = (state != CHAR) && !(state == IDLE && px_req);
  end

`ifdef TEXT_SCHEDULER_CURSOR_EN
  logic [CELL_W-1:0]    cursor;
  logic [BLINK_DIV-1:0] blinkCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor   <= '0;
      blinkCnt <= '0;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
      if (wrAccept) cursor <= wr_addr + 1'b1;  // 6-bit wrap is intended
    end
  end

  assign captureByte = (blinkCnt[BLINK_DIV-1] && (reqCell == cursor)) ? ~font_data : font_data;
`else
  assign captureByte = font_data;
`endif

  // Request datapath. font_addr is launched on leaving CHAR, so later writes to
  // the same cell cannot change the byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqAddr   <= '0;
      waitCnt   <= '0;
      font_addr <= '0;
      px_data   <= '0;
    end else begin
      if (state == IDLE && px_req) reqAddr <= px_addr;
      if (state == CHAR) begin
        font_addr <= fontAddrNext;
        waitCnt   <= WAIT_LOAD;
      end else if (state == WAIT && waitCnt != 2'd0) begin
        waitCnt <= waitCnt - 2'd1;
      end
      if (state == WAIT && waitCnt == 2'd0) px_data <= captureByte;
    end
  end

endmodule
